// File: rtl/stopwatch_pkg.sv
// Shared types and display-driver digit codes for the stopwatch core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } sw_state_t;

  // Codes understood by the seven-segment driver's decode table.
  localparam logic [3:0] CODE_H    = 4'd10;
  localparam logic [3:0] CODE_I    = 4'd11;
  localparam logic [3:0] CODE_DASH = 4'd15;

endpackage

// File: rtl/bcd_digit.sv
// One modulo-MOD counter stage of the stopwatch's BCD cascade.
module bcd_digit #(
  parameter int MOD = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  localparam logic [3:0] Q_MAX = 4'(MOD - 1);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    // NOTE: default first, so every path assigns q_d and no latch is inferred.
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (inc) begin
      q_d = (q_q == Q_MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  // NOTE: non-blocking assignments for every flop, reset taking priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc && (q_q == Q_MAX);

endmodule

// File: rtl/stopwatch_digits.sv
// Stopwatch core: button edge detect, run/pause FSM, 0.1 s prescaler and BCD
// digits feeding the seven-segment multiplexer; shows "HI--" after 9:59.9.
module stopwatch_digits
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] fourth,
  output logic [3:0] third,
  output logic [3:0] second,
  output logic [3:0] first,
  output logic       running,
  output logic       overflow
);

  localparam int             PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

  sw_state_t     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          start_q, clear_q;
  logic          running_q, running_d;
  logic          overflow_q, overflow_d;

  logic          start_rise, clear_rise, tick, at_max, tick_inc, digit_clr;
  logic [3:0]    tenths, secs, tens, mins;
  logic          c_tenths, c_secs, c_tens, carry_unused;

  assign start_rise = start_stop & ~start_q;
  assign clear_rise = clear & ~clear_q;
  assign tick       = (state_q == RUN) && (presc_q == PRESC_MAX);
  assign at_max     = (mins == 4'd9) && (tens == 4'd5) && (secs == 4'd9) && (tenths == 4'd9);
  // A tick at 9:59.9 moves to OVER instead of wrapping the digits.
  assign tick_inc   = tick && !at_max;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_rise) state_d = RUN;
      RUN: begin
        if (tick && at_max)  state_d = OVER;
        else if (start_rise) state_d = PAUSE;
      end
      PAUSE: begin
        if (clear_rise)      state_d = IDLE;
        else if (start_rise) state_d = RUN;
      end
      OVER:    if (clear_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    presc_d = presc_q;
    if (state_d == IDLE || state_d == OVER) begin
      presc_d = '0;
    end else if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    digit_clr  = (state_d == IDLE);
    running_d  = (state_d == RUN);
    overflow_d = (state_d == OVER);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      start_q    <= 1'b0;
      clear_q    <= 1'b0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      start_q    <= start_stop;
      clear_q    <= clear;
      running_q  <= running_d;
      overflow_q <= overflow_d;
    end
  end

  bcd_digit #(.MOD(10)) u_tenths (
    .clock(clock), .reset(reset), .clr(digit_clr), .inc(tick_inc),
    .q(tenths), .carry(c_tenths)
  );
  bcd_digit #(.MOD(10)) u_secs (
    .clock(clock), .reset(reset), .clr(digit_clr), .inc(c_tenths),
    .q(secs), .carry(c_secs)
  );
  bcd_digit #(.MOD(6)) u_tens (
    .clock(clock), .reset(reset), .clr(digit_clr), .inc(c_secs),
    .q(tens), .carry(c_tens)
  );
  bcd_digit #(.MOD(10)) u_mins (
    .clock(clock), .reset(reset), .clr(digit_clr), .inc(c_tens),
    .q(mins), .carry(carry_unused)
  );

  always_comb begin
    fourth = mins;
    third  = tens;
    second = secs;
    first  = tenths;
    if (state_q == OVER) begin
      fourth = CODE_H;
      third  = CODE_I;
      second = CODE_DASH;
      first  = CODE_DASH;
    end
  end

  assign running  = running_q;
  assign overflow = overflow_q;

endmodule
